// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SPI-mode SD command engine.
//   resp_type_t : response format selector (values match resp_type encoding)
//   state_t     : command engine FSM states
//   DATA_TOKEN / IDLE_BYTE : start-of-block token and bus-idle byte
//   CMDx        : command bytes with start/transmission bits already set
package sd_pkg;

   typedef enum logic [1:0] {
      RESP_R1    = 2'd0,
      RESP_R1_32 = 2'd1,
      RESP_DATA  = 2'd2
   } resp_type_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PRE,
      ST_SEND,
      ST_WAIT_R1,
      ST_RECV_R1,
      ST_RECV_EXT,
      ST_WAIT_TOKEN,
      ST_RECV_DATA,
      ST_RECV_CRC,
      ST_POST,
      ST_DONE
   } state_t;

   localparam logic [7:0] DATA_TOKEN = 8'hFE;
   localparam logic [7:0] IDLE_BYTE  = 8'hFF;

   localparam logic [7:0] CMD0   = 8'h40;
   localparam logic [7:0] CMD8   = 8'h48;
   localparam logic [7:0] CMD16  = 8'h50;
   localparam logic [7:0] CMD17  = 8'h51;
   localparam logic [7:0] CMD55  = 8'h77;
   localparam logic [7:0] ACMD41 = 8'h69;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sd_spi_cmd_engine_if.sv
// sd_spi_cmd_engine_if: request/response bundle between the init/read
// sequencer (master) and the SD command engine (slave).
//   start, cmd_byte, cmd_arg, cmd_crc, resp_type : request (master -> slave)
//   busy, done, resp_r1, resp_data, err_timeout, err_token : status/results
interface sd_spi_cmd_engine_if;
   logic        start;
   logic [7:0]  cmd_byte;
   logic [31:0] cmd_arg;
   logic [7:0]  cmd_crc;
   logic [1:0]  resp_type;
   logic        busy;
   logic        done;
   logic [7:0]  resp_r1;
   logic [31:0] resp_data;
   logic        err_timeout;
   logic        err_token;

   modport master (
      output start, cmd_byte, cmd_arg, cmd_crc, resp_type,
      input  busy, done, resp_r1, resp_data, err_timeout, err_token
   );

   modport slave (
      input  start, cmd_byte, cmd_arg, cmd_crc, resp_type,
      output busy, done, resp_r1, resp_data, err_timeout, err_token
   );
endinterface

// File: rtl/sd_bit_shifter.sv
// sd_bit_shifter: 48-bit parallel-load/serial-out TX register (MSB first,
// back-filled with 1s so an over-shifted frame idles high) and a 32-bit
// serial-in RX register (MSB first).
//   clk, reset          : clock, synchronous active-high reset
//   tx_ld_i, tx_din_i   : load a full frame
//   tx_sh_i, tx_msb_o   : shift TX left, current MSB
//   rx_clr_i            : clear RX (wins over shift)
//   rx_sh_i, rx_bit_i   : shift one bit into RX
//   rx_o                : RX contents
module sd_bit_shifter (
   input  logic        clk,
   input  logic        reset,
   input  logic        tx_ld_i,
   input  logic [47:0] tx_din_i,
   input  logic        tx_sh_i,
   output logic        tx_msb_o,
   input  logic        rx_clr_i,
   input  logic        rx_sh_i,
   input  logic        rx_bit_i,
   output logic [31:0] rx_o
);
   logic [47:0] tx_q;
   logic [31:0] rx_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_q <= '1;
         rx_q <= '0;
      end else begin
         if (tx_ld_i)      tx_q <= tx_din_i;
         else if (tx_sh_i) tx_q <= {tx_q[46:0], 1'b1};
         if (rx_clr_i)     rx_q <= '0;
         else if (rx_sh_i) rx_q <= {rx_q[30:0], rx_bit_i};
      end
   end

   assign tx_msb_o = tx_q[47];
   assign rx_o     = rx_q;
endmodule

// File: rtl/sd_spi_cmd_engine.sv
// sd_spi_cmd_engine: SPI-mode SD command engine, one bit per SD clock.
// Sends PRE_CLKS idle-high clocks, a 48-bit command frame MSB first, hunts
// for the R1 start bit (NCR_MAX clocks), captures R1, then optionally a
// 32-bit trailer or a data block (token wait bounded by TOKEN_MAX_BYTES),
// POST_CLKS idle clocks and a one-cycle done pulse.
//   clk, reset : SD clock, synchronous active-high reset
//   miso       : card data out
//   mosi       : card data in (high whenever not sending a frame)
//   mosi_oe    : MOSI drive enable (always driven)
//   bus        : request/response interface, slave side
module sd_spi_cmd_engine
   import sd_pkg::*;
#(
   parameter int PRE_CLKS        = 8,
   parameter int NCR_MAX         = 64,
   parameter int TOKEN_MAX_BYTES = 1024,
   parameter int BLOCK_BYTES     = 4,
   parameter int POST_CLKS       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              miso,
   output logic              mosi,
   output logic              mosi_oe,
   sd_spi_cmd_engine_if.slave bus
);
   localparam int CNT_TOP = max_int(max_int(48, NCR_MAX),
                                    max_int(BLOCK_BYTES * 8, max_int(PRE_CLKS, POST_CLKS)));
   localparam int CW = $clog2(CNT_TOP + 1);
   localparam int BW = $clog2(TOKEN_MAX_BYTES + 1);
   // bit counter counts down; data bits above this value land in resp_data
   localparam logic [CW-1:0] DATA_KEEP = CW'(BLOCK_BYTES * 8 - 32);

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic [BW-1:0]  bcnt_q;
   logic [1:0]     rtype_q;
   logic [7:0]     r1_q;
   logic           mosi_q, busy_q, done_q, to_q, tok_q;

   logic           tx_ld, tx_sh, tx_msb, rx_clr, rx_sh, cnt_zero;
   logic [31:0]    rx;
   logic [7:0]     r1_d, tok_d;

   assign cnt_zero = (cnt_q == '0);
   assign r1_d     = {r1_q[6:0], miso};
   assign tok_d    = {rx[6:0], miso};

   assign tx_ld = (state_q == ST_IDLE) && bus.start;
   // shift once at the PRE->SEND edge so tx_msb already holds the next bit
   assign tx_sh = ((state_q == ST_PRE) && cnt_zero) || (state_q == ST_SEND);
   // token bytes are assembled in RX; clearing after each idle byte leaves an
   // error token as {24'h0, byte}
   assign rx_sh = (state_q == ST_RECV_EXT) || (state_q == ST_WAIT_TOKEN) ||
                  ((state_q == ST_RECV_DATA) && (cnt_q >= DATA_KEEP));
   assign rx_clr = tx_ld ||
                   ((state_q == ST_WAIT_TOKEN) && cnt_zero && (tok_d == IDLE_BYTE));

   sd_bit_shifter u_shift (
      .clk      (clk),
      .reset    (reset),
      .tx_ld_i  (tx_ld),
      .tx_din_i ({bus.cmd_byte, bus.cmd_arg, bus.cmd_crc}),
      .tx_sh_i  (tx_sh),
      .tx_msb_o (tx_msb),
      .rx_clr_i (rx_clr),
      .rx_sh_i  (rx_sh),
      .rx_bit_i (miso),
      .rx_o     (rx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bcnt_q  <= '0;
         rtype_q <= '0;
         r1_q    <= IDLE_BYTE;
         mosi_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
         tok_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!cnt_zero) cnt_q <= cnt_q - CW'(1);
         case (state_q)
            ST_IDLE: if (bus.start) begin
               state_q <= ST_PRE;
               cnt_q   <= CW'(PRE_CLKS - 1);
               rtype_q <= bus.resp_type;
               r1_q    <= IDLE_BYTE;
               to_q    <= 1'b0;
               tok_q   <= 1'b0;
               busy_q  <= 1'b1;
            end
            ST_PRE: if (cnt_zero) begin
               state_q <= ST_SEND;
               cnt_q   <= CW'(47);
               mosi_q  <= tx_msb;
            end
            ST_SEND: begin
               mosi_q <= tx_msb;
               if (cnt_zero) begin
                  state_q <= ST_WAIT_R1;
                  cnt_q   <= CW'(NCR_MAX - 1);
                  mosi_q  <= 1'b1;
               end
            end
            ST_WAIT_R1: begin
               if (!miso) begin
                  r1_q    <= r1_d;
                  state_q <= ST_RECV_R1;
                  cnt_q   <= CW'(6);
               end else if (cnt_zero) begin
                  to_q    <= 1'b1;
                  state_q <= ST_POST;
                  cnt_q   <= CW'(POST_CLKS - 1);
               end
            end
            ST_RECV_R1: begin
               r1_q <= r1_d;
               if (cnt_zero) begin
                  if (rtype_q == RESP_R1_32) begin
                     state_q <= ST_RECV_EXT;
                     cnt_q   <= CW'(31);
                  end else if ((rtype_q == RESP_DATA) && (r1_d == 8'h00)) begin
                     state_q <= ST_WAIT_TOKEN;
                     cnt_q   <= CW'(7);
                     bcnt_q  <= BW'(TOKEN_MAX_BYTES - 1);
                  end else begin
                     state_q <= ST_POST;
                     cnt_q   <= CW'(POST_CLKS - 1);
                  end
               end
            end
            ST_RECV_EXT: if (cnt_zero) begin
               state_q <= ST_POST;
               cnt_q   <= CW'(POST_CLKS - 1);
            end
            ST_WAIT_TOKEN: if (cnt_zero) begin
               if (tok_d == IDLE_BYTE) begin
                  if (bcnt_q == '0) begin
                     to_q    <= 1'b1;
                     state_q <= ST_POST;
                     cnt_q   <= CW'(POST_CLKS - 1);
                  end else begin
                     bcnt_q <= bcnt_q - BW'(1);
                     cnt_q  <= CW'(7);
                  end
               end else if (tok_d == DATA_TOKEN) begin
                  state_q <= ST_RECV_DATA;
                  cnt_q   <= CW'(BLOCK_BYTES * 8 - 1);
               end else begin
                  tok_q   <= 1'b1;
                  state_q <= ST_POST;
                  cnt_q   <= CW'(POST_CLKS - 1);
               end
            end
            ST_RECV_DATA: if (cnt_zero) begin
               state_q <= ST_RECV_CRC;
               cnt_q   <= CW'(15);
            end
            ST_RECV_CRC: if (cnt_zero) begin
               state_q <= ST_POST;
               cnt_q   <= CW'(POST_CLKS - 1);
            end
            ST_POST: if (cnt_zero) begin
               state_q <= ST_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mosi            = mosi_q;
   assign mosi_oe         = 1'b1;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.resp_r1     = r1_q;
   assign bus.resp_data   = rx;
   assign bus.err_timeout = to_q;
   assign bus.err_token   = tok_q;
endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Bench for sd_spi_cmd_engine: a card model plays a bit stream on MISO
// starting at the first R1-hunt clock; a transaction-level model derives
// R1/trailer/token results and the done cycle from that stream, and a
// per-cycle compare process checks mosi/busy/done against the timeline.
module tb_sd_spi_cmd_engine;
   import sd_pkg::*;

   localparam int PRE = 8, NCR = 64, TOKMAX = 1024, BLK = 4, POST = 8;

   logic clk = 1'b0, reset = 1'b1, miso;
   logic mosi, mosi_oe;
   sd_spi_cmd_engine_if bus();

   sd_spi_cmd_engine #(.PRE_CLKS(PRE), .NCR_MAX(NCR), .TOKEN_MAX_BYTES(TOKMAX),
                       .BLOCK_BYTES(BLK), .POST_CLKS(POST)) dut (
      .clk(clk), .reset(reset), .miso(miso), .mosi(mosi), .mosi_oe(mosi_oe), .bus(bus));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0, n_fail = 0;

   task automatic check(input string nm, input logic [47:0] got, input logic [47:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // card stream and model results
   bit          rbits [0:511];
   int          rlen = 0;
   logic [47:0] frame = '0, cap = '0;
   logic [7:0]  e_r1 = 8'hFF;
   logic [31:0] e_data = '0, e_mask = '0;
   logic        e_to = 1'b0, e_tok = 1'b0;
   int          e_dk = 0, A = 0, busy_cnt = 0, done_cnt = 0;
   bit          act = 1'b0;

   function automatic logic bitat(input int j);
      return (j >= 0 && j < rlen) ? rbits[j] : 1'b1;
   endfunction

   function automatic logic [31:0] grab(input int j, input int n);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v = {v[30:0], bitat(j + i)};
      return v;
   endfunction

   task automatic add_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin rbits[rlen] = b[i]; rlen++; end
   endtask

   task automatic add_ones(input int n);
      for (int i = 0; i < n; i++) begin rbits[rlen] = 1'b1; rlen++; end
   endtask

   // what the card stream must produce, and how many response bits it consumes
   task automatic model(input logic [1:0] rt);
      int used, i0;
      bit hit;
      logic [7:0] b;
      e_to = 0; e_tok = 0; e_data = '0; e_mask = '0; e_r1 = 8'hFF; hit = 0; i0 = 0;
      for (int i = 0; i < NCR; i++) if (!hit && bitat(i) == 1'b0) begin hit = 1; i0 = i; end
      if (!hit) begin
         e_to = 1; used = NCR;
      end else begin
         e_r1 = 8'(grab(i0, 8)); used = i0 + 8;
         if (rt == 2'd1) begin
            e_data = grab(used, 32); e_mask = '1; used += 32;
         end else if (rt == 2'd2 && e_r1 == 8'h00) begin
            hit = 0;
            for (int n = 0; n < TOKMAX && !hit; n++) begin
               b = 8'(grab(used, 8)); used += 8;
               if (b == 8'hFE) begin
                  e_data = grab(used, 32); e_mask = '1; used += BLK * 8 + 16; hit = 1;
               end else if (b != 8'hFF) begin
                  e_tok = 1; e_data = {24'h0, b}; e_mask = 32'hFF; hit = 1;
               end
            end
            if (!hit) e_to = 1;
         end
      end
      e_dk = PRE + 48 + used + POST;
   endtask

   task automatic start_txn(input logic [7:0] cb, input logic [31:0] arg,
                            input logic [7:0] crc, input logic [1:0] rt);
      frame = {cb, arg, crc};
      model(rt);
      busy_cnt = 0; done_cnt = 0; cap = '0;
      bus.cmd_byte = cb; bus.cmd_arg = arg; bus.cmd_crc = crc; bus.resp_type = rt;
      bus.start = 1'b1; A = cyc + 1; act = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic finish_txn();
      while (cyc - A < e_dk + 2) @(negedge clk);
      act = 1'b0;
   endtask

   // card: bit j of the stream is on MISO during the j-th R1-hunt clock
   always @(negedge clk) begin
      int k;
      k = cyc - A;
      miso = (act && k >= PRE + 48 && k <= e_dk) ? bitat(k - PRE - 48) : 1'b1;
   end

   // per-cycle compare against the model timeline
   always @(negedge clk) begin
      int k;
      logic eb, ed, em;
      if (!reset) begin
         k = cyc - A; eb = 1'b0; ed = 1'b0; em = 1'b1;
         if (act && k >= 0) begin
            eb = (k < e_dk);
            ed = (k == e_dk);
            if (k >= PRE && k < PRE + 48) em = frame[47 - (k - PRE)];
         end
         check("mosi", 48'(mosi), 48'(em));
         check("mosi_oe", 48'(mosi_oe), 48'(1'b1));
         check("busy", 48'(bus.busy), 48'(eb));
         check("done", 48'(bus.done), 48'(ed));
         if (act && k >= 0) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            if (k >= PRE && k < PRE + 48) cap = {cap[46:0], mosi};
         end
         if (act && k == e_dk) begin
            check("resp_r1", 48'(bus.resp_r1), 48'(e_r1));
            check("resp_data", 48'(bus.resp_data & e_mask), 48'(e_data & e_mask));
            check("err_timeout", 48'(bus.err_timeout), 48'(e_to));
            check("err_token", 48'(bus.err_token), 48'(e_tok));
         end
      end
   end

   initial begin
      bus.start = 1'b0; bus.cmd_byte = '0; bus.cmd_arg = '0; bus.cmd_crc = '0; bus.resp_type = '0;
      repeat (3) @(negedge clk);
      check("rst_mosi", 48'(mosi), 48'(1'b1));
      check("rst_busy", 48'(bus.busy), 48'(1'b0));
      check("rst_done", 48'(bus.done), 48'(1'b0));
      check("rst_r1", 48'(bus.resp_r1), 48'hFF);
      check("rst_data", 48'(bus.resp_data), 48'h0);
      check("rst_errs", 48'({bus.err_timeout, bus.err_token}), 48'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // CMD0, R1 0x01 after two idle clocks; busy = 8 + 48 + (2 idle + start bit) + 7 + 8
      rlen = 0; add_ones(2); add_byte(8'h01);
      start_txn(CMD0, 32'h0, 8'h95, 2'd0); finish_txn();
      check("t1_frame", cap, 48'h400000000095);
      check("t1_r1", 48'(bus.resp_r1), 48'h01);
      check("t1_busy_cycles", 48'(busy_cnt), 48'd74);
      check("t1_done_pulses", 48'(done_cnt), 48'd1);

      // CMD8, R1 + 32-bit trailer
      rlen = 0; add_ones(3); add_byte(8'h01);
      add_byte(8'h00); add_byte(8'h00); add_byte(8'h01); add_byte(8'hAA);
      start_txn(CMD8, 32'h1AA, 8'h87, 2'd1); finish_txn();
      check("t2_r1", 48'(bus.resp_r1), 48'h01);
      check("t2_data", 48'(bus.resp_data), 48'h1AA);
      check("t2_errs", 48'({bus.err_timeout, bus.err_token}), 48'h0);

      // CMD17 block read: 3 idle bytes, token, DE AD BE EF, CRC
      rlen = 0; add_ones(1); add_byte(8'h00);
      add_byte(8'hFF); add_byte(8'hFF); add_byte(8'hFF); add_byte(8'hFE);
      add_byte(8'hDE); add_byte(8'hAD); add_byte(8'hBE); add_byte(8'hEF);
      add_byte(8'h12); add_byte(8'h34);
      start_txn(CMD17, 32'h0, 8'hFF, 2'd2); finish_txn();
      check("t3_data", 48'(bus.resp_data), 48'hDEADBEEF);
      check("t3_err_token", 48'(bus.err_token), 48'h0);
      check("t3_busy_cycles", 48'(busy_cnt), 48'd153);
      check("t3_done_pulses", 48'(done_cnt), 48'd1);

      // CMD17, data error token 0x05
      rlen = 0; add_ones(1); add_byte(8'h00); add_byte(8'h05);
      start_txn(CMD17, 32'h200, 8'hFF, 2'd2); finish_txn();
      check("t4_err_token", 48'(bus.err_token), 48'h1);
      check("t4_data_lo", 48'(bus.resp_data[7:0]), 48'h05);

      // no response at all: NCR timeout
      rlen = 0;
      start_txn(ACMD41, 32'h4000_0000, 8'hFF, 2'd0); finish_txn();
      check("t5_err_timeout", 48'(bus.err_timeout), 48'h1);
      check("t5_r1", 48'(bus.resp_r1), 48'hFF);
      check("t5_busy_cycles", 48'(busy_cnt), 48'd128);

      // data request with nonzero R1: no token wait even though a token follows
      rlen = 0; add_byte(8'h04); add_byte(8'hFE); add_byte(8'hDE);
      start_txn(CMD17, 32'h0, 8'hFF, 2'd2); finish_txn();
      check("t6_r1", 48'(bus.resp_r1), 48'h04);
      check("t6_busy_cycles", 48'(busy_cnt), 48'd72);

      // reserved response type behaves as plain R1
      rlen = 0; add_ones(2); add_byte(8'h01); add_byte(8'h00); add_byte(8'hFE);
      start_txn(CMD0, 32'h0, 8'h95, 2'd3); finish_txn();
      check("t7_busy_cycles", 48'(busy_cnt), 48'd74);

      // start while busy is ignored: frame and response type stay as latched
      rlen = 0; add_ones(1); add_byte(8'h00);
      start_txn(CMD16, 32'h200, 8'h15, 2'd0);
      repeat (3) @(negedge clk);
      bus.cmd_byte = CMD55; bus.cmd_arg = 32'hFFFF_FFFF; bus.cmd_crc = 8'h00;
      bus.resp_type = 2'd2; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      finish_txn();
      check("t8_frame", cap, {CMD16, 32'h200, 8'h15});
      check("t8_done_pulses", 48'(done_cnt), 48'd1);

      // reset in the middle of SEND
      rlen = 0; add_ones(1); add_byte(8'h01);
      start_txn(CMD55, 32'h0, 8'h65, 2'd0);
      repeat (20) @(negedge clk);
      reset = 1'b1; act = 1'b0;
      @(negedge clk);
      check("t9_mosi", 48'(mosi), 48'(1'b1));
      check("t9_busy", 48'(bus.busy), 48'(1'b0));
      check("t9_done", 48'(bus.done), 48'(1'b0));
      check("t9_r1", 48'(bus.resp_r1), 48'hFF);
      reset = 1'b0;
      repeat (100) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
